// File: rtl/lsu_seq_if.sv
// Core/BRAM-facing bundle of the load/store sequencer: request, response
// and the synchronous-read data BRAM port.
interface lsu_seq_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  req_valid;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_we;
    logic [31:0]           mem_din;
    logic [31:0]           mem_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_din
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/lsu_seq.sv
// Load/store sequencer: splits word-crossing accesses into two aligned BRAM
// accesses, merges/extends load data and stalls the core until done.
module lsu_seq #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic       clk,
    input  logic       rst,
    lsu_seq_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR0, WR1, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [2:0]            f3;
        logic [ADDR_WIDTH-1:0] word;
        logic [1:0]            off;
        logic [31:0]           wdata;
        logic                  err;
    } req_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nx;
    req_t                  held, cur;
    logic [31:0]           lo, hi;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic [3:0]            we_q, we_nx;
    logic [31:0]           din_q, din_nx;
    logic                  illegal_in, spans;
    logic [2:0]            nbytes;
    logic [7:0]            mask8;
    logic [63:0]           wsh;
    logic [31:0]           x, ext;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

    always_comb begin
        if (bus.req_we)
            illegal_in = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                           bus.req_funct3 == 3'b010);
        else
            illegal_in = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end

    // In IDLE the live request drives the datapath so WR0 values can be
    // registered on the accept edge; afterwards only the held copy is used.
    always_comb begin
        cur = held;
        if (state == IDLE) begin
            cur.we    = bus.req_we;
            cur.f3    = bus.req_funct3;
            cur.word  = bus.req_addr[ADDR_WIDTH+1:2];
            cur.off   = bus.req_addr[1:0];
            cur.wdata = bus.req_wdata;
            cur.err   = illegal_in;
        end
    end

    always_comb begin
        case (cur.f3[1:0])
            2'b00:   begin nbytes = 3'd1; mask8 = 8'h01 << cur.off; end
            2'b01:   begin nbytes = 3'd2; mask8 = 8'h03 << cur.off; end
            default: begin nbytes = 3'd4; mask8 = 8'h0F << cur.off; end
        endcase
        spans = ({2'b00, cur.off} + {1'b0, nbytes}) > 4'd4;
        wsh   = {32'h0, cur.wdata} << {cur.off, 3'b000};
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        we_nx    = 4'b0000;
        din_nx   = din_q;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (cur.err) begin
                    state_nx = RESP;
                end else if (cur.we) begin
                    state_nx = WR0;
                    addr_nx  = cur.word;
                    we_nx    = mask8[3:0];
                    din_nx   = wsh[31:0];
                end else begin
                    state_nx = RD0;
                    addr_nx  = cur.word;
                end
            end
            RD0: begin
                state_nx = RD1;
                addr_nx  = held.word + ONE;
            end
            RD1: state_nx = spans ? RD2 : RESP;
            RD2: state_nx = RESP;
            WR0: if (spans) begin
                state_nx = WR1;
                addr_nx  = held.word + ONE;
                we_nx    = mask8[7:4];
                din_nx   = wsh[63:32];
            end else begin
                state_nx = RESP;
            end
            WR1:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            we_q   <= 4'b0000;
            din_q  <= '0;
            lo     <= '0;
            hi     <= '0;
            held   <= '0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            we_q   <= we_nx;
            din_q  <= din_nx;
            if (state == IDLE && bus.req_valid)
                held <= cur;
            // hi is cleared here so non-spanning loads merge against zero
            if (state == RD1) begin
                lo <= bus.mem_dout;
                hi <= '0;
            end
            if (state == RD2)
                hi <= bus.mem_dout;
        end
    end

    always_comb begin
        x = 32'({hi, lo} >> {held.off, 3'b000});
        case (held.f3)
            3'b000:  ext = {{24{x[7]}}, x[7:0]};
            3'b001:  ext = {{16{x[15]}}, x[15:0]};
            3'b010:  ext = x;
            3'b100:  ext = {24'h0, x[7:0]};
            3'b101:  ext = {16'h0, x[15:0]};
            default: ext = '0;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && held.err;
    assign bus.resp_rdata = (state == RESP && !held.we && !held.err) ? ext : 32'h0;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_din    = din_q;
endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq with a behavioural synchronous-read BRAM.
module tb_lsu_seq;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_seq_if #(.ADDR_WIDTH(AW)) bus();
    lsu_seq #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_din[8*i +: 8];
        bus.mem_dout <= mem[bus.mem_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] alog [1:10];
    logic [3:0]    wlog [1:10];
    logic [31:0]   dlog [1:10];
    int            lat;
    logic [31:0]   rd;
    logic          er;
    logic          we_any;
    logic          seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Issue one request, then log the BRAM port each cycle until resp_valid.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'hFFFF_FFFF;
        lat = -1; we_any = 1'b0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            alog[c] = bus.mem_addr;
            wlog[c] = bus.mem_we;
            dlog[c] = bus.mem_din;
            we_any  = we_any | (|bus.mem_we);
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'h0);

        // reset and request in the same cycle: request is dropped
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b011;
        @(posedge clk); #1;
        rst = 1'b0; bus.req_valid = 1'b0;
        chk("rstreq_ready", 32'(bus.req_ready), 32'd1);
        chk("rstreq_no_resp", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rstreq_no_resp2", 32'(bus.resp_valid), 32'd0);

        // aligned LW
        preload(14'h40, 32'hDEADBEEF);
        run(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_rd0_addr", 32'(alog[1]), 32'h40);
        chk("lw_no_we", 32'(we_any), 32'd0);

        // spanning LH / LHU
        preload(14'h40, 32'hAA000000);
        preload(14'h41, 32'h000000BB);
        run(1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh_lat", 32'(lat), 32'd4);
        chk("lh_rdata", rd, 32'hFFFFBBAA);
        chk("lh_rd1_addr", 32'(alog[2]), 32'h41);
        run(1'b0, 3'b101, 32'h103, 32'h0);
        chk("lhu_lat", 32'(lat), 32'd4);
        chk("lhu_rdata", rd, 32'h0000BBAA);

        // spanning SW
        preload(14'h40, 32'h0);
        preload(14'h41, 32'h0);
        run(1'b1, 3'b010, 32'h102, 32'h11223344);
        chk("sw_lat", 32'(lat), 32'd3);
        chk("sw_wr0_addr", 32'(alog[1]), 32'h40);
        chk("sw_wr0_we", 32'(wlog[1]), 32'hC);
        chk("sw_wr0_din", dlog[1], 32'h33440000);
        chk("sw_wr1_addr", 32'(alog[2]), 32'h41);
        chk("sw_wr1_we", 32'(wlog[2]), 32'h3);
        chk("sw_wr1_din", dlog[2], 32'h00001122);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_mem40", mem[14'h40], 32'h33440000);
        chk("sw_mem41", mem[14'h41], 32'h00001122);

        // non-spanning SB: only byte lane 1 written
        preload(14'h40, 32'h0);
        run(1'b1, 3'b000, 32'h101, 32'hFFFFFFA5);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_we", 32'(wlog[1]), 32'h2);
        chk("sb_din", dlog[1], 32'hFFFFA500);
        chk("sb_mem40", mem[14'h40], 32'h0000A500);

        // LB / LBU at top byte
        preload(14'h0, 32'h80FF0000);
        run(1'b0, 3'b000, 32'h003, 32'h0);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h003, 32'h0);
        chk("lbu_lat", 32'(lat), 32'd3);
        chk("lbu_rdata", rd, 32'h00000080);

        // illegal funct3
        run(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        chk("ill_ld_err", 32'(er), 32'd1);
        chk("ill_ld_rdata", rd, 32'h0);
        chk("ill_ld_no_we", 32'(we_any), 32'd0);
        run(1'b1, 3'b100, 32'h100, 32'h12345678);
        chk("ill_st_lat", 32'(lat), 32'd1);
        chk("ill_st_err", 32'(er), 32'd1);
        chk("ill_st_no_we", 32'(we_any), 32'd0);

        // top-word wrap of the second read
        preload(14'h3FFF, 32'h44332211);
        run(1'b0, 3'b010, 32'h0000FFFD, 32'h0);
        chk("wrap_lat", 32'(lat), 32'd4);
        chk("wrap_rd0_addr", 32'(alog[1]), 32'h3FFF);
        chk("wrap_rd1_addr", 32'(alog[2]), 32'h0);
        chk("wrap_rdata", rd, 32'h00443322);

        // reset during WR1 of a split store
        preload(14'h40, 32'h0);
        preload(14'h41, 32'h0);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h102; bus.req_wdata = 32'h11223344;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_wr1_we", 32'(bus.mem_we), 32'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        seen = bus.resp_valid;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | bus.resp_valid;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        chk("abort_wr0_kept", mem[14'h40], 32'h33440000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_seq.md
# lsu_seq

Load/store sequencer between the core's memory stage and the synchronous-read data BRAM. It accepts one load or store request at a time and splits accesses that cross a 32-bit word boundary into two aligned word accesses. It merges the two read words, then extracts and sign- or zero-extends the requested byte or halfword. It stalls the core via `req_ready` until the access completes.

## Interface
- `ADDR_WIDTH`, 14, word-address width of the data BRAM.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; sampled only when `req_ready`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_ready` out 1: 1 only in IDLE.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; illegal funct3.
- `mem_addr` out ADDR_WIDTH: registered word address.
- `mem_we` out 4: registered byte write enables; bit i covers `mem_din[8i+7:8i]`.
- `mem_din` out 32: registered write data.
- `mem_dout` in 32: BRAM read data, valid the cycle after `mem_addr` is presented.

## Operation
- Capture on accept (`req_valid & req_ready`): `A = req_addr[ADDR_WIDTH+1:2]`, `off = req_addr[1:0]`, size n = 1/2/4 from funct3[1:0].
- `spans = (off + n > 4)`. Second word is `A+1` modulo 2^ADDR_WIDTH, so the top word wraps to 0.
- Illegal funct3 goes to RESP with `resp_err`=1 and makes no memory access:
  - loads: 011, 110, 111;
  - stores: any value other than 000/001/010.
- States:
  - IDLE: `req_ready`=1. On accept, go to RD0 (load), WR0 (store) or RESP (illegal).
  - RD0: `mem_addr`=A, `mem_we`=0. Go to RD1.
  - RD1: latch `mem_dout` as lo and present `mem_addr`=A+1. If spans, go to RD2; else go to RESP.
  - RD2: latch `mem_dout` as hi. Go to RESP.
  - WR0: `mem_addr`=A, `mem_din = wdata << 8·off`, `mem_we = (n-byte mask << off)[3:0]`. If spans, go to WR1; else go to RESP.
  - WR1: `mem_addr`=A+1, `mem_din = wdata >> 8·(4-off)`, `mem_we = (n-byte mask << off)[7:4]`. Go to RESP.
  - RESP: `resp_valid`=1. Go to IDLE.
- Load extract: `x = ({hi,lo} >> 8·off)`, keep the low n bytes.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU/LW zero-extend.
  - hi is treated as 0 when the access does not span.
- `mem_we`=0 in every state except WR0/WR1.
- `resp_rdata` and `resp_err` hold their value only during RESP and are 0 otherwise.
- `req_*` inputs are ignored outside IDLE; the held values are used throughout the access.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Latency, counted in cycles from the accept edge to the cycle with `resp_valid`=1:
  - aligned or non-spanning load: 3;
  - spanning load: 4;
  - non-spanning store: 2;
  - spanning store: 3;
  - illegal: 1.
- Back-to-back: the next accept can occur in the cycle after RESP (IDLE). Throughput is at most one request per latency+1 cycles.
- `rst` mid-operation: the next cycle is IDLE with every output at its reset value. A split store reset during WR1 keeps its WR0 write (no rollback). No `resp_valid` is issued for the aborted request.
- `rst` and `req_valid` asserted in the same cycle: `rst` wins and the request is not accepted.

## Test plan
- LW 0x100, mem[0x40]=0xDEADBEEF:
  - `mem_addr`=0x40 in RD0;
  - `resp_valid` at accept+3 with rdata 0xDEADBEEF;
  - `resp_err`=0.
- LH 0x103, mem[0x40]=0xAA000000, mem[0x41]=0x000000BB:
  - `resp_valid` at accept+4 with rdata 0xFFFFBBAA;
  - LHU at the same address gives 0x0000BBAA.
- SW 0x102, data 0x11223344:
  - WR0: addr 0x40, we 1100, din 0x33440000;
  - WR1: addr 0x41, we 0011, din 0x00001122;
  - `resp_valid` at accept+3.
- LB and LBU 0x003 with mem[0]=0x80FF0000:
  - LB gives 0xFFFFFF80;
  - LBU gives 0x00000080;
  - both take 3 cycles with no second read.
- Illegal load funct3=011:
  - `resp_valid` and `resp_err` at accept+1;
  - rdata 0;
  - `mem_we` stays 0.
- LW at byte address 4·(2^ADDR_WIDTH−1)+1: second read uses `mem_addr`=0.
- Reset during WR1 of the SW above:
  - next cycle shows IDLE, `mem_we`=0, `req_ready`=1;
  - no `resp_valid` pulse.
